// File: rtl/aes_round_sched.sv
// aes_round_sched: control-path sequencer for the iterative AES-128 core.
// Steps the shared round datapath through the initial AddRoundKey, NR-1 full
// rounds and the final round. It also drives the key-expansion enable and the
// round constant. The result is held valid until the consumer takes it.
module aes_round_sched #(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          ld_init,
    output logic          round_en,
    output logic          key_en,
    output logic          last_round,
    output logic [RW-1:0] round_idx,
    output logic [7:0]    rcon
);

    localparam int unsigned RCON_W = 8;
    localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;
    localparam logic [RW-1:0]     IDX_LAST_FULL = RW'(NR - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       round_idx_q, round_idx_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                ld_init_q, ld_init_d;
    logic                round_en_q, round_en_d;
    logic                key_en_q, key_en_d;
    logic                last_round_q, last_round_d;
    logic                key_adv;

    // GF(2^8) multiply-by-x used to advance the round constant
    function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Next-state, round counter/rcon update and registered control decode
    always_comb begin
        state_d      = state_q;
        round_idx_d  = round_idx_q;
        rcon_d       = rcon_q;
        key_adv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                key_adv = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                key_adv = 1'b1;
                if (round_idx_q == IDX_LAST_FULL) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                    rcon_d      = RCON_INIT;
                end
            end
            default: begin
                state_d     = IDLE;
                round_idx_d = '0;
                rcon_d      = RCON_INIT;
            end
        endcase

        // Key schedule moves one step on every cycle that key_en is presented
        if (key_adv) begin
            round_idx_d = round_idx_q + RW'(1);
            rcon_d      = xtime(rcon_q);
        end

        // Abort overrides everything, including out_ready in DONE
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            round_idx_d = '0;
            rcon_d      = RCON_INIT;
        end

        // Controls are registered from the next state so they align with state_q
        ld_init_d    = (state_d == LOAD);
        round_en_d   = (state_d == LOAD) || (state_d == ROUND) || (state_d == FINAL);
        key_en_d     = (state_d == LOAD) || (state_d == ROUND);
        last_round_d = (state_d == FINAL);
        out_valid_d  = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // State and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            round_idx_q  <= '0;
            rcon_q       <= RCON_INIT;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ld_init_q    <= 1'b0;
            round_en_q   <= 1'b0;
            key_en_q     <= 1'b0;
            last_round_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_idx_q  <= round_idx_d;
            rcon_q       <= rcon_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            ld_init_q    <= ld_init_d;
            round_en_q   <= round_en_d;
            key_en_q     <= key_en_d;
            last_round_q <= last_round_d;
        end
    end

    // in_ready is the only output allowed to see an input combinationally
    assign in_ready   = (state_q == IDLE) && !abort;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ld_init    = ld_init_q;
    assign round_en   = round_en_q;
    assign key_en     = key_en_q;
    assign last_round = last_round_q;
    assign round_idx  = round_idx_q;
    assign rcon       = rcon_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed self-checking bench for aes_round_sched.
module tb_aes_round_sched;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       ld_init;
    logic       round_en;
    logic       key_en;
    logic       last_round;
    logic [3:0] round_idx;
    logic [7:0] rcon;

    int total;
    int bad;
    int cnt;
    logic [7:0] rtab [10];

    aes_round_sched #(.NR(10), .RW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .ld_init    (ld_init),
        .round_en   (round_en),
        .key_en     (key_en),
        .last_round (last_round),
        .round_idx  (round_idx),
        .rcon       (rcon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset-like idle state with every control low
    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},      32'(busy),       32'd0);
        chk({tag, ".idx"},       32'(round_idx),  32'd0);
        chk({tag, ".rcon"},      32'(rcon),       32'h01);
        chk({tag, ".out_valid"}, 32'(out_valid),  32'd0);
        chk({tag, ".round_en"},  32'(round_en),   32'd0);
        chk({tag, ".key_en"},    32'(key_en),     32'd0);
        chk({tag, ".ld_init"},   32'(ld_init),    32'd0);
        chk({tag, ".last"},      32'(last_round), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rtab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rst       = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;

        // Reset values
        #12;
        chk_idle("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        step();

        // Single operation, full rcon sequence
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("op1.ld_init",  32'(ld_init),   32'd1);
        chk("op1.round_en", 32'(round_en),  32'd1);
        chk("op1.key_en",   32'(key_en),    32'd1);
        chk("op1.idx0",     32'(round_idx), 32'd0);
        chk("op1.rcon0",    32'(rcon),      32'h01);
        chk("op1.busy",     32'(busy),      32'd1);
        chk("op1.in_ready", 32'(in_ready),  32'd0);
        for (int k = 1; k < 10; k++) begin
            step();
            chk($sformatf("op1.idx%0d", k),  32'(round_idx),  32'(k));
            chk($sformatf("op1.rcon%0d", k), 32'(rcon),       32'(rtab[k]));
            chk($sformatf("op1.key%0d", k),  32'(key_en),     32'd1);
            chk($sformatf("op1.last%0d", k), 32'(last_round), 32'd0);
            chk($sformatf("op1.ld%0d", k),   32'(ld_init),    32'd0);
        end
        step();
        chk("op1.final.idx",  32'(round_idx),  32'd10);
        chk("op1.final.last", 32'(last_round), 32'd1);
        chk("op1.final.key",  32'(key_en),     32'd0);
        chk("op1.final.ren",  32'(round_en),   32'd1);
        chk("op1.final.ov",   32'(out_valid),  32'd0);
        step();
        chk("op1.done.ov",    32'(out_valid), 32'd1);
        chk("op1.done.ren",   32'(round_en),  32'd0);
        chk("op1.done.inrdy", 32'(in_ready),  32'd0);
        step();
        chk_idle("op1.after");
        chk("op1.after.in_ready", 32'(in_ready), 32'd1);

        // Output backpressure with in_valid held high throughout
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        chk("bp.ld_init", 32'(ld_init), 32'd1);
        repeat (11) step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp.ov%0d", k),    32'(out_valid), 32'd1);
            chk($sformatf("bp.idx%0d", k),   32'(round_idx), 32'd10);
            chk($sformatf("bp.ren%0d", k),   32'(round_en),  32'd0);
            chk($sformatf("bp.key%0d", k),   32'(key_en),    32'd0);
            chk($sformatf("bp.ld%0d", k),    32'(ld_init),   32'd0);
            chk($sformatf("bp.last%0d", k),  32'(last_round), 32'd0);
            chk($sformatf("bp.inrdy%0d", k), 32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk_idle("bp.idle");
        chk("bp.idle.in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp.reaccept", 32'(ld_init), 32'd1);

        // Abort at round_idx=4
        repeat (4) step();
        chk("abort.idx4", 32'(round_idx), 32'd4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort.in_ready", 32'(in_ready), 32'd1);

        // Fresh request after abort completes with the full sequence
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_abort.ld", 32'(ld_init), 32'd1);
        chk("post_abort.rcon0", 32'(rcon), 32'h01);
        for (int k = 1; k < 10; k++) begin
            step();
            chk($sformatf("post_abort.rcon%0d", k), 32'(rcon), 32'(rtab[k]));
        end
        step();
        chk("post_abort.last", 32'(last_round), 32'd1);
        step();
        chk("post_abort.ov", 32'(out_valid), 32'd1);
        step();
        chk("post_abort.idle", 32'(busy), 32'd0);

        // Asynchronous reset between edges at round_idx=7
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("arst.idx7", 32'(round_idx), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        step();
        chk("arst.still_idle", 32'(busy), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("arst.resume.ld", 32'(ld_init), 32'd1);
        repeat (11) step();
        chk("arst.resume.ov", 32'(out_valid), 32'd1);
        step();
        chk("arst.resume.idle", 32'(busy), 32'd0);

        // Abort blocks accept in IDLE
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        chk("abort_idle.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("abort_idle.busy", 32'(busy),    32'd0);
        chk("abort_idle.ld",   32'(ld_init), 32'd0);
        abort = 1'b0;
        #1;
        chk("abort_idle.in_ready1", 32'(in_ready), 32'd1);

        // Back-to-back requests: accept spacing of 13 cycles
        step();
        chk("b2b.ld_first", 32'(ld_init), 32'd1);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!ld_init && cnt < 40);
        in_valid = 1'b0;
        chk("b2b.spacing", 32'(cnt), 32'd13);

        // Abort beats out_ready in DONE
        repeat (11) step();
        chk("abort_done.ov", 32'(out_valid), 32'd1);
        abort     = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk_idle("abort_done");
        chk("abort_done.in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
